// File: rtl/uart_tx_if.sv
// Register-side and line-side signals of the UART transmitter.
// slave is the transmitter; master is whoever writes bytes and owns the line.
interface uart_tx_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_tx_en;
  logic [PAYLOAD_BITS-1:0] uart_tx_data;
  logic                    uart_tx_busy;
  logic                    uart_tx_active;
  logic                    uart_txd;
  logic                    uart_cts;

  modport master (
    output uart_tx_en, uart_tx_data, uart_cts,
    input  uart_tx_busy, uart_tx_active, uart_txd
  );

  modport slave (
    input  uart_tx_en, uart_tx_data, uart_cts,
    output uart_tx_busy, uart_tx_active, uart_txd
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding register, start/data/stop serialiser,
// CTS-gated frame launch with back-to-back frames when the next byte is ready.
module uart_tx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave tx
);
  localparam int BIT_PERIOD = CLK_HZ / BIT_RATE;
  localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int BW = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                  state_q;
  logic [TW-1:0]           timer_q;
  logic [BW-1:0]           bit_q;
  logic                    stop_q;
  logic [PAYLOAD_BITS-1:0] hold_q;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic                    hold_full_q;
  logic                    txd_q;
  logic                    active_q;
  logic                    cts_meta_q;
  logic                    cts_sync_q;

  logic bit_done_d;
  logic last_stop_d;
  logic go_d;

  assign bit_done_d  = (timer_q == TIMER_LAST);
  assign last_stop_d = (STOP_BITS == 1) || stop_q;
  // Launch from idle, or seamlessly on the final clock of the last stop bit.
  assign go_d = hold_full_q && !cts_sync_q &&
                ((state_q == IDLE) || ((state_q == STOP) && bit_done_d && last_stop_d));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
      active_q    <= 1'b0;
      cts_meta_q  <= 1'b1;
      cts_sync_q  <= 1'b1;
    end else begin
      cts_meta_q <= tx.uart_cts;
      cts_sync_q <= cts_meta_q;

      // busy is the pre-edge hold_full_q, so a write never collides with a launch.
      if (tx.uart_tx_en && !hold_full_q) begin
        hold_q      <= tx.uart_tx_data;
        hold_full_q <= 1'b1;
      end

      if (go_d) begin
        shift_q     <= hold_q;
        hold_full_q <= 1'b0;
        state_q     <= START;
        txd_q       <= 1'b0;
        active_q    <= 1'b1;
        timer_q     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            timer_q  <= '0;
            txd_q    <= 1'b1;
            active_q <= 1'b0;
          end
          START: begin
            if (bit_done_d) begin
              state_q <= DATA;
              timer_q <= '0;
              bit_q   <= '0;
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          DATA: begin
            if (bit_done_d) begin
              timer_q <= '0;
              if (bit_q == DATA_LAST) begin
                state_q <= STOP;
                stop_q  <= 1'b0;
                txd_q   <= 1'b1;
              end else begin
                bit_q   <= bit_q + 1'b1;
                txd_q   <= shift_q[0];
                shift_q <= shift_q >> 1;
              end
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          STOP: begin
            txd_q <= 1'b1;
            if (bit_done_d) begin
              timer_q <= '0;
              if (last_stop_d) begin
                state_q  <= IDLE;
                active_q <= 1'b0;
              end else begin
                stop_q <= 1'b1;
              end
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          default: begin
            state_q  <= IDLE;
            txd_q    <= 1'b1;
            active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx.uart_txd       = txd_q;
  assign tx.uart_tx_busy   = hold_full_q;
  assign tx.uart_tx_active = active_q;
endmodule
